status_reg_stack: RTL and testbench

STATUS_REG_STACK -- requirements
Module: status_reg_stack

---
 rtl/status_reg_stack.sv | 99 +++++++++
 tb/tb_status_reg_stack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/status_reg_stack.sv
// Processor status register (condition flags + mode) with a shadow stack that
// saves context on trap and restores it on return; HALT freezes everything until reset.
module status_reg_stack #(
  parameter int FLAG_W = 4,
  parameter int MODE_W = 1,
  parameter int DEPTH  = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       upd_en,
  input  logic [FLAG_W-1:0]          upd_mask,
  input  logic [FLAG_W-1:0]          flags_in,
  input  logic                       wr_en,
  input  logic [FLAG_W+MODE_W-1:0]   wr_data,
  input  logic                       trap,
  input  logic [MODE_W-1:0]          trap_mode,
  input  logic                       ret,
  input  logic                       halt,
  output logic [FLAG_W-1:0]          flags,
  output logic [MODE_W-1:0]          mode,
  output logic                       halted,
  output logic [DW-1:0]              depth,
  output logic                       stk_ovf,
  output logic                       stk_unf
);

  localparam int SW = FLAG_W + MODE_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, HALTED} state_e;

  state_e            state_q;
  logic [FLAG_W-1:0] flags_q;
  logic [MODE_W-1:0] mode_q;
  logic              halted_q;
  logic [DW-1:0]     depth_q;
  logic              ovf_q;
  logic              unf_q;
  logic [SW-1:0]     stk_q [DEPTH];

  logic          full;
  logic          empty;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign push_idx = AW'(depth_q);
  assign pop_idx  = AW'(depth_q - DW'(1));

  // One action per cycle in RUN: halt > trap > ret > wr_en > upd_en.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      flags_q  <= '0;
      mode_q   <= '0;
      halted_q <= 1'b0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (state_q == RUN) begin
      if (halt) begin
        state_q  <= HALTED;
        flags_q  <= '1;
        mode_q   <= '1;
        halted_q <= 1'b1;
      end else if (trap) begin
        if (!full) begin
          stk_q[push_idx] <= {flags_q, mode_q};
          mode_q          <= trap_mode;
          depth_q         <= depth_q + DW'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (ret) begin
        if (!empty) begin
          {flags_q, mode_q} <= stk_q[pop_idx];
          depth_q           <= depth_q - DW'(1);
        end else begin
          unf_q <= 1'b1;
        end
      end else if (wr_en) begin
        flags_q <= wr_data[SW-1:MODE_W];
        mode_q  <= wr_data[MODE_W-1:0];
      end else if (upd_en) begin
        flags_q <= (flags_q & ~upd_mask) | (flags_in & upd_mask);
      end
    end
  end

  assign flags   = flags_q;
  assign mode    = mode_q;
  assign halted  = halted_q;
  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_status_reg_stack.sv
// Bench for status_reg_stack: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_status_reg_stack;

  localparam int FLAG_W = 4;
  localparam int MODE_W = 1;
  localparam int DEPTH  = 4;
  localparam int DW     = $clog2(DEPTH + 1);
  localparam int SW     = FLAG_W + MODE_W;

  logic              clock = 1'b0;
  logic              reset, upd_en, wr_en, trap, ret, halt;
  logic [FLAG_W-1:0] upd_mask, flags_in;
  logic [SW-1:0]     wr_data;
  logic [MODE_W-1:0] trap_mode;
  logic [FLAG_W-1:0] flags;
  logic [MODE_W-1:0] mode;
  logic              halted, stk_ovf, stk_unf;
  logic [DW-1:0]     depth;

  status_reg_stack #(.FLAG_W(FLAG_W), .MODE_W(MODE_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .upd_en(upd_en), .upd_mask(upd_mask),
    .flags_in(flags_in), .wr_en(wr_en), .wr_data(wr_data), .trap(trap),
    .trap_mode(trap_mode), .ret(ret), .halt(halt), .flags(flags), .mode(mode),
    .halted(halted), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model: architectural status plus a queue used as the shadow stack.
  logic [FLAG_W-1:0] m_flags;
  logic [MODE_W-1:0] m_mode;
  logic              m_halted, m_ovf, m_unf;
  logic [SW-1:0]     m_stk[$];

  task automatic model_edge();
    if (reset) begin
      m_flags = '0; m_mode = '0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete();
    end else if (!m_halted) begin
      if (halt) begin
        m_flags = '1; m_mode = '1; m_halted = 1'b1;
      end else if (trap) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back({m_flags, m_mode});
          m_mode = trap_mode;
        end else m_ovf = 1'b1;
      end else if (ret) begin
        if (m_stk.size() > 0) {m_flags, m_mode} = m_stk.pop_back();
        else m_unf = 1'b1;
      end else if (wr_en) begin
        {m_flags, m_mode} = wr_data;
      end else if (upd_en) begin
        for (int i = 0; i < FLAG_W; i++) if (upd_mask[i]) m_flags[i] = flags_in[i];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("model.flags",   32'(flags),   32'(m_flags));
      chk("model.mode",    32'(mode),    32'(m_mode));
      chk("model.halted",  32'(halted),  32'(m_halted));
      chk("model.depth",   32'(depth),   32'(m_stk.size()));
      chk("model.stk_ovf", 32'(stk_ovf), 32'(m_ovf));
      chk("model.stk_unf", 32'(stk_unf), 32'(m_unf));
    end
  end

  task automatic idle();
    reset = 0; upd_en = 0; upd_mask = '0; flags_in = '0; wr_en = 0; wr_data = '0;
    trap = 0; trap_mode = '0; ret = 0; halt = 0;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    chk_on = 1'b1;
    @(negedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();  reset = 1; step(); endtask
  task automatic do_upd(input logic [3:0] m, input logic [3:0] f);
    upd_en = 1; upd_mask = m; flags_in = f; step();
  endtask
  task automatic do_wr(input logic [SW-1:0] d); wr_en = 1; wr_data = d; step(); endtask
  task automatic do_trap(input logic [MODE_W-1:0] tm); trap = 1; trap_mode = tm; step(); endtask
  task automatic do_ret(); ret = 1; step(); endtask

  initial begin
    logic [MODE_W-1:0] tms [5];
    tms = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    idle();
    @(negedge clock);

    // Reset state
    do_reset();
    chk("rst.flags", 32'(flags), 0);
    chk("rst.depth", 32'(depth), 0);
    chk("rst.halted", 32'(halted), 0);

    // Masked flag update
    do_upd(4'b1100, 4'b1111);
    chk("upd1.flags", 32'(flags), 32'b1100);
    do_upd(4'b0011, 4'b0001);
    chk("upd2.flags", 32'(flags), 32'b1101);
    do_upd(4'b0000, 4'b0000);
    chk("upd0.flags", 32'(flags), 32'b1101);

    // Trap / explicit write / return
    do_wr(5'b1010_0);
    do_trap(1'b1);
    chk("trap.mode", 32'(mode), 1);
    chk("trap.flags", 32'(flags), 32'b1010);
    chk("trap.depth", 32'(depth), 1);
    do_wr(5'b0101_1);
    chk("wr.flags", 32'(flags), 32'b0101);
    do_ret();
    chk("ret.flags", 32'(flags), 32'b1010);
    chk("ret.mode", 32'(mode), 0);
    chk("ret.depth", 32'(depth), 0);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) do_trap(tms[i]);
    chk("ovf.depth", 32'(depth), 4);
    chk("ovf.flag", 32'(stk_ovf), 1);
    chk("ovf.mode", 32'(mode), 1);
    for (int i = 0; i < 5; i++) do_ret();
    chk("unf.depth", 32'(depth), 0);
    chk("unf.flag", 32'(stk_unf), 1);
    chk("unf.flags", 32'(flags), 32'b1010);
    chk("unf.mode", 32'(mode), 0);
    chk("unf.ovf_sticky", 32'(stk_ovf), 1);

    // All requests together: only the push happens
    do_reset();
    do_wr(5'b0110_0);
    trap = 1; trap_mode = 1'b1; ret = 1; wr_en = 1; wr_data = 5'b1111_0;
    upd_en = 1; upd_mask = 4'hF; flags_in = 4'h9;
    step();
    chk("prio.depth", 32'(depth), 1);
    chk("prio.flags", 32'(flags), 32'b0110);
    chk("prio.mode", 32'(mode), 1);

    // Reset beats a trap at depth 2
    do_trap(1'b0);
    chk("pre.depth", 32'(depth), 2);
    reset = 1; trap = 1; trap_mode = 1'b1; step();
    chk("rsttrap.depth", 32'(depth), 0);
    chk("rsttrap.mode", 32'(mode), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      halt      = ($urandom_range(0, 399) == 0);
      trap      = ($urandom_range(0, 3) == 0);
      ret       = ($urandom_range(0, 3) == 0);
      wr_en     = ($urandom_range(0, 4) == 0);
      upd_en    = $urandom_range(0, 1);
      upd_mask  = FLAG_W'($urandom);
      flags_in  = FLAG_W'($urandom);
      wr_data   = SW'($urandom);
      trap_mode = MODE_W'($urandom);
      step();
    end

    // Halt freezes state until reset
    do_reset();
    do_wr(5'b0011_0);
    halt = 1; step();
    chk("halt.flags", 32'(flags), 32'hF);
    chk("halt.mode", 32'(mode), 1);
    chk("halt.halted", 32'(halted), 1);
    do_upd(4'hF, 4'h0);
    do_trap(1'b0);
    do_wr(5'b0000_0);
    do_ret();
    chk("hold.flags", 32'(flags), 32'hF);
    chk("hold.mode", 32'(mode), 1);
    chk("hold.depth", 32'(depth), 0);
    do_reset();
    chk("unhalt.flags", 32'(flags), 0);
    chk("unhalt.mode", 32'(mode), 0);
    chk("unhalt.halted", 32'(halted), 0);
    chk("unhalt.ovf", 32'(stk_ovf), 0);
    chk("unhalt.unf", 32'(stk_unf), 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
